bfly_r2_dit_pipe: RTL and testbench
===================================

Name: bfly_r2_dit_pipe

Overview:
- Pipelined radix-2 decimation-in-time butterfly: multiply by the twiddle first, then add/subtract. It is the counterpart of the combinational DIF butterfly.
- Serves the inverse-FFT / DIT datapath. Compute: t = X1·W (W conjugated when inv=1), Y0 = X0 + t, Y1 = X0 − t.
- Optional per-stage 1/2 scaling.
- Valid/ready streaming interface, fixed 3-cycle latency, full-throughput stall pipeline.

Parameters:
- DataWidth, 16, width of the X/Y real and imaginary parts (signed two's complement).
- TwFrac, DataWidth-2, twiddle fractional bits (Q1.TwFrac); unity = 2^TwFrac.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input accepted when in_valid && in_ready
- X0_Re, X0_Im, X1_Re, X1_Im  in  DataWidth each  signed input pair
- W_Re, W_Im  in  DataWidth each  signed twiddle, Q1.TwFrac
- inv  in  1  1 = use conj(W) (inverse transform); sampled with the beat
- scale  in  1  1 = divide outputs by 2; sampled with the beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- Y0_Re, Y0_Im, Y1_Re, Y1_Im  out  DataWidth each  signed results
- ovf  out  1  per-beat flag: saturation occurred on any of the 4 outputs (qualified by out_valid)

Behaviour:
- Reset (async, rst=1): all stage valid bits = 0, all data registers = 0, out_valid=0, ovf=0, all Y = 0. in_ready=1 during and after reset.
- Global advance: en = !out_valid || out_ready.
  - in_ready = en (combinational).
  - When en=1, all three stages shift.
  - When en=0, every stage holds.
  - Bubbles are not collapsed.
- Pipeline stages:
  - S1: register X0, X1, W, inv, scale, valid. If inv=1, register W_Im as −W_Im. Negating −2^(DataWidth-1) saturates to 2^(DataWidth-1)−1.
  - S2: four full-precision 2·DataWidth products.
    - tr = X1r·Wr − X1i·Wi
    - ti = X1r·Wi + X1i·Wr
    - Round half-up: add 2^(TwFrac−1), then arithmetic shift right by TwFrac.
    - Keep t at DataWidth+2 bits; no truncation here.
    - Register t and the delayed X0.
  - S3: s = X0 ± t at DataWidth+3 bits.
    - If scale=1: s = (s + 1) >>> 1.
    - Then saturate or wrap to DataWidth (see Optional Feature).
    - Register Y0/Y1 and ovf.
- Latency: an input accepted at edge k produces out_valid at edge k+3 if never stalled. Stall cycles add 1:1.
- Throughput: 1 beat per clock while out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, all Y and ovf hold constant.
- Simultaneous accept/release (out_valid=1, out_ready=1, in_valid=1): the output retires and the new input enters S1 on the same edge.
- in_valid=0 with en=1: a bubble enters S1 and its valid bit is 0.
- Reset mid-stream: all in-flight beats are discarded immediately (asynchronous). No partial output appears after reset deasserts.
- W=(2^TwFrac, 0) is exact unity; the result then equals the DIF butterfly with cos=1, sin=0.

Optional Feature:
- Macro: BFLY_R2_SAT_EN.
- Defined: S3 clamps each output to [−2^(DataWidth-1), 2^(DataWidth-1)−1]. ovf=1 for a beat if any of the 4 outputs was clamped.
- Undefined: outputs take the low DataWidth bits (two's-complement wrap). ovf is tied to 0. No comparator logic is generated.

Decomposition:
- Shared package fft_pkg:
  - DataWidth / TwFrac default constants
  - unity-twiddle constant
  - round_shift function (add half-LSB, arithmetic shift)
  - saturate function (N→DataWidth with overflow bit)
- One sub-module: bfly_cmul, the S2 complex multiplier. It contains the 4 products, the rounding and the t register, with an enable input. It is reusable by a later radix-4 block.

Test Plan (DataWidth=16, TwFrac=14, out_ready=1 unless stated):
- Unity twiddle: W=(16384,0), X0=(1000,200), X1=(300,−100), inv=0, scale=0 → 3 cycles later Y0=(1300,100), Y1=(700,300), ovf=0.
- −j twiddle: W=(0,−16384), same X, inv=0 → Y0=(900,−100), Y1=(1100,500).
- Inverse mode: W=(0,−16384), same X, inv=1 (conj = +j) → Y0=(1100,500), Y1=(900,−100).
- Overflow: X0=X1=(32767,0), W=unity, scale=0.
  - With macro: Y0_Re=32767, ovf=1, Y1=(0,0).
  - Without macro: Y0_Re=−2, ovf=0.
  - Same inputs with scale=1 → Y0_Re=32767, ovf=0.
- Backpressure: stream 5 beats, hold out_ready=0 for 4 cycles after the first out_valid.
  - in_ready is low during the hold and Y is stable.
  - On release, all 5 results emerge in order with no loss or duplication.
- Reset mid-stream: assert rst asynchronously with 3 beats in flight → out_valid=0 and Y=0 immediately. After deassertion, no stale beat appears and in_ready=1.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and arithmetic helpers (rounding shift, saturation).
package fft_pkg;
  localparam int DATA_W  = 16;
  localparam int TW_FRAC = DATA_W - 2;
  localparam logic signed [DATA_W-1:0] TW_UNITY = DATA_W'(64'd1 << TW_FRAC);

  // All intermediate math is done in 64 bits; callers slice the result.
  typedef logic signed [63:0] wide_t;

  typedef struct packed {
    logic  ovf;
    wide_t val;
  } sat_t;

  // Round half-up: add half an output LSB, then arithmetic shift.
  function automatic wide_t round_shift(input wide_t v, input int unsigned sh);
    return (v + (wide_t'(1) <<< (sh - 1))) >>> sh;
  endfunction

  function automatic sat_t saturate(input wide_t v, input int unsigned dw);
    wide_t hi, lo;
    sat_t  r;
    hi    = (wide_t'(1) <<< (dw - 1)) - 1;
    lo    = -hi - 1;
    r.ovf = (v > hi) || (v < lo);
    r.val = (v > hi) ? hi : ((v < lo) ? lo : v);
    return r;
  endfunction
endpackage

// File: rtl/bfly_cmul.sv
// Registered complex multiply t = a*w with half-up rounding of the Q1.TwFrac twiddle.
module bfly_cmul import fft_pkg::*; #(
  parameter int DataWidth = DATA_W,
  parameter int TwFrac    = DataWidth - 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic signed [DataWidth-1:0] a_re,
  input  logic signed [DataWidth-1:0] a_im,
  input  logic signed [DataWidth-1:0] w_re,
  input  logic signed [DataWidth-1:0] w_im,
  output logic signed [DataWidth+1:0] t_re,
  output logic signed [DataWidth+1:0] t_im
);
  localparam int TW = DataWidth + 2;

  wide_t pr, pi;
  logic  unused_hi;

  always_comb begin
    pr = round_shift(wide_t'(a_re) * wide_t'(w_re) - wide_t'(a_im) * wide_t'(w_im), TwFrac);
    pi = round_shift(wide_t'(a_re) * wide_t'(w_im) + wide_t'(a_im) * wide_t'(w_re), TwFrac);
  end

  // t keeps two guard bits above DataWidth; only |W| near 2 can exceed that.
  assign unused_hi = ^{pr[63:TW], pi[63:TW]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_re <= '0;
      t_im <= '0;
    end else if (en) begin
      t_re <= pr[TW-1:0];
      t_im <= pi[TW-1:0];
    end
  end
endmodule

// File: rtl/bfly_r2_dit_pipe.sv
// 3-stage radix-2 DIT butterfly with valid/ready stall pipeline.
// Define BFLY_R2_SAT_EN to saturate outputs and report ovf; otherwise outputs wrap.
module bfly_r2_dit_pipe import fft_pkg::*; #(
  parameter int DataWidth = DATA_W,
  parameter int TwFrac    = DataWidth - 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DataWidth-1:0] X0_Re,
  input  logic signed [DataWidth-1:0] X0_Im,
  input  logic signed [DataWidth-1:0] X1_Re,
  input  logic signed [DataWidth-1:0] X1_Im,
  input  logic signed [DataWidth-1:0] W_Re,
  input  logic signed [DataWidth-1:0] W_Im,
  input  logic                        inv,
  input  logic                        scale,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [DataWidth-1:0] Y0_Re,
  output logic signed [DataWidth-1:0] Y0_Im,
  output logic signed [DataWidth-1:0] Y1_Re,
  output logic signed [DataWidth-1:0] Y1_Im,
  output logic                        ovf
);
  localparam int STAGES = 3;
  localparam logic signed [DataWidth-1:0] SMAX = {1'b0, {(DataWidth-1){1'b1}}};
  localparam logic signed [DataWidth-1:0] SMIN = {1'b1, {(DataWidth-1){1'b0}}};

  logic              en;
  logic [STAGES:1]   vld_pipe;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];

  // S1: capture beat; conjugation folded into the twiddle, -MIN clamps to MAX.
  logic signed [DataWidth-1:0] x0r1, x0i1, x1r1, x1i1, wr1, wi1, wi_n;
  logic                        scl1;

  always_comb wi_n = !inv ? W_Im : ((W_Im == SMIN) ? SMAX : -W_Im);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      {x0r1, x0i1, x1r1, x1i1, wr1, wi1} <= '0;
      scl1 <= 1'b0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      x0r1 <= X0_Re;  x0i1 <= X0_Im;
      x1r1 <= X1_Re;  x1i1 <= X1_Im;
      wr1  <= W_Re;   wi1  <= wi_n;
      scl1 <= scale;
    end
  end

  // S2: twiddle product alongside the delayed X0.
  logic signed [DataWidth+1:0] tr2, ti2;
  logic signed [DataWidth-1:0] x0r2, x0i2;
  logic                        scl2;

  bfly_cmul #(.DataWidth(DataWidth), .TwFrac(TwFrac)) u_cmul (
    .clk (clk), .rst (rst), .en (en),
    .a_re(x1r1), .a_im(x1i1), .w_re(wr1), .w_im(wi1),
    .t_re(tr2), .t_im(ti2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {x0r2, x0i2} <= '0;
      scl2 <= 1'b0;
    end else if (en) begin
      x0r2 <= x0r1;
      x0i2 <= x0i1;
      scl2 <= scl1;
    end
  end

  // S3: add/subtract, optional halving, then narrow to DataWidth.
  wide_t                       sum [4];
  logic [3:0][DataWidth-1:0]   y_n;
  logic                        ovf_n;
  logic                        unused_hi;

  always_comb begin
    sum[0] = wide_t'(x0r2) + wide_t'(tr2);
    sum[1] = wide_t'(x0i2) + wide_t'(ti2);
    sum[2] = wide_t'(x0r2) - wide_t'(tr2);
    sum[3] = wide_t'(x0i2) - wide_t'(ti2);
    if (scl2)
      for (int k = 0; k < 4; k++) sum[k] = round_shift(sum[k], 1);
  end

`ifdef BFLY_R2_SAT_EN
  sat_t sat [4];
  always_comb begin
    ovf_n     = 1'b0;
    unused_hi = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sat[k]    = saturate(sum[k], DataWidth);
      y_n[k]    = sat[k].val[DataWidth-1:0];
      ovf_n     = ovf_n | sat[k].ovf;
      unused_hi = unused_hi ^ (^sat[k].val[63:DataWidth]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ovf <= 1'b0;
    else if (en) ovf <= ovf_n;
  end
`else
  always_comb begin
    ovf_n     = 1'b0;
    unused_hi = 1'b0;
    for (int k = 0; k < 4; k++) begin
      y_n[k]    = sum[k][DataWidth-1:0];
      unused_hi = unused_hi ^ (^sum[k][63:DataWidth]);
    end
  end

  assign ovf = ovf_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {Y0_Re, Y0_Im, Y1_Re, Y1_Im} <= '0;
    end else if (en) begin
      Y0_Re <= y_n[0];
      Y0_Im <= y_n[1];
      Y1_Re <= y_n[2];
      Y1_Im <= y_n[3];
    end
  end
endmodule

// File: tb/tb_bfly_r2_dit_pipe.sv
// Self-checking bench for bfly_r2_dit_pipe: vector table, random stream, backpressure, mid-stream reset.
module tb_bfly_r2_dit_pipe;
  typedef struct { logic signed [15:0] x0r, x0i, x1r, x1i, wr, wi; logic inv, scale; } in_t;
  typedef struct { logic signed [15:0] y0r, y0i, y1r, y1i; logic ovf; } out_t;
  typedef struct { in_t i; out_t o; } vec_t;
  typedef struct { out_t o; int cyc; } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, inv = 1'b0, scale = 1'b0, ovf;
  logic signed [15:0] X0_Re = 0, X0_Im = 0, X1_Re = 0, X1_Im = 0, W_Re = 0, W_Im = 0;
  logic signed [15:0] Y0_Re, Y0_Im, Y1_Re, Y1_Im;

  bfly_r2_dit_pipe #(.DataWidth(16), .TwFrac(14)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .X0_Re(X0_Re), .X0_Im(X0_Im), .X1_Re(X1_Re), .X1_Im(X1_Im),
    .W_Re(W_Re), .W_Im(W_Im), .inv(inv), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .Y0_Re(Y0_Re), .Y0_Im(Y0_Im), .Y1_Re(Y1_Re), .Y1_Im(Y1_Im), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int   n_vec = 0, n_err = 0, cyc = 0, hold_req = 0, stalls = 0;
  logic chk_lat = 1'b0, held = 1'b0;
  out_t snap;
  exp_t sbq[$];

  function automatic in_t mk_in(int a, int b, int c, int d, int e, int f, int iv, int sc);
    in_t v;
    v.x0r = 16'(a); v.x0i = 16'(b); v.x1r = 16'(c); v.x1i = 16'(d);
    v.wr = 16'(e); v.wi = 16'(f); v.inv = iv[0]; v.scale = sc[0];
    return v;
  endfunction

  function automatic out_t mk_out(int a, int b, int c, int d, int o);
    out_t v;
    v.y0r = 16'(a); v.y0i = 16'(b); v.y1r = 16'(c); v.y1i = 16'(d); v.ovf = o[0];
    return v;
  endfunction

  function automatic longint fdiv(longint a, longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  // Reference: exact integer arithmetic with floor division.
  function automatic out_t model(in_t v);
    longint wi, tr, ti;
    longint s [4];
    logic   o;
    out_t   r;
    wi = longint'(v.wi);
    if (v.inv) wi = (wi == -32768) ? 32767 : -wi;
    tr = fdiv(longint'(v.x1r) * longint'(v.wr) - longint'(v.x1i) * wi + 8192, 16384);
    ti = fdiv(longint'(v.x1r) * wi + longint'(v.x1i) * longint'(v.wr) + 8192, 16384);
    s[0] = longint'(v.x0r) + tr; s[1] = longint'(v.x0i) + ti;
    s[2] = longint'(v.x0r) - tr; s[3] = longint'(v.x0i) - ti;
    o = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (v.scale) s[k] = fdiv(s[k] + 1, 2);
`ifdef BFLY_R2_SAT_EN
      if (s[k] > 32767)  begin s[k] = 32767;  o = 1'b1; end
      if (s[k] < -32768) begin s[k] = -32768; o = 1'b1; end
`endif
    end
    r.y0r = 16'(s[0]); r.y0i = 16'(s[1]); r.y1r = 16'(s[2]); r.y1i = 16'(s[3]); r.ovf = o;
    return r;
  endfunction

  function automatic in_t rnd_in();
    in_t v;
    v.x0r = 16'($urandom); v.x0i = 16'($urandom);
    v.x1r = 16'($urandom); v.x1i = 16'($urandom);
    v.wr  = 16'(int'($urandom_range(0, 32768)) - 16384);
    v.wi  = 16'(int'($urandom_range(0, 32768)) - 16384);
    v.inv = 1'($urandom_range(0, 1)); v.scale = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic out_t get_out();
    out_t v;
    v.y0r = Y0_Re; v.y0i = Y0_Im; v.y1r = Y1_Re; v.y1i = Y1_Im; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk_out(input string nm, input out_t a, input out_t e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got Y0=(%0d,%0d) Y1=(%0d,%0d) ovf=%0b, want Y0=(%0d,%0d) Y1=(%0d,%0d) ovf=%0b",
               nm, a.y0r, a.y0i, a.y1r, a.y1i, a.ovf, e.y0r, e.y0i, e.y1r, e.y1i, e.ovf);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, retire/push for the coming posedge.
  task automatic step(input logic iv, input in_t d, input logic ordy, input out_t eo, output logic fired);
    exp_t e;
    @(negedge clk);
    cyc++;
    if (out_valid && hold_req > 0) begin out_ready = 1'b0; hold_req--; end
    else out_ready = ordy;
    in_valid = iv;
    X0_Re = d.x0r; X0_Im = d.x0i; X1_Re = d.x1r; X1_Im = d.x1i;
    W_Re = d.wr; W_Im = d.wi; inv = d.inv; scale = d.scale;
    #1;
    if (held) chk_out("hold_stable", get_out(), snap);
    held = 1'b0;
    if (out_valid && !out_ready) begin
      stalls++;
      chk_int("in_ready_stall", int'(in_ready), 0);
      snap = get_out();
      held = 1'b1;
    end
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_beat: got out_valid=1 want no beat");
      end else begin
        e = sbq.pop_front();
        chk_out("beat", get_out(), e.o);
        if (chk_lat) chk_int("latency", cyc - e.cyc, 3);
      end
    end
    fired = iv && in_ready;
    if (fired) begin
      e.o = eo; e.cyc = cyc;
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    logic f;
    in_t  z;
    z = mk_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 40 && sbq.size() != 0; c++) step(1'b0, z, 1'b1, mk_out(0, 0, 0, 0, 0), f);
    if (sbq.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d beats outstanding want 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    vec_t tab [10];
    in_t  v, z;
    logic f;
    int   got;

    tab[0] = '{mk_in(1000, 200, 300, -100, 16384, 0, 0, 0),      mk_out(1300, 100, 700, 300, 0)};
    tab[1] = '{mk_in(1000, 200, 300, -100, 0, -16384, 0, 0),     mk_out(900, -100, 1100, 500, 0)};
    tab[2] = '{mk_in(1000, 200, 300, -100, 0, -16384, 1, 0),     mk_out(1100, 500, 900, -100, 0)};
`ifdef BFLY_R2_SAT_EN
    tab[3] = '{mk_in(32767, 0, 32767, 0, 16384, 0, 0, 0),        mk_out(32767, 0, 0, 0, 1)};
    tab[5] = '{mk_in(-32768, 0, -32768, 0, 16384, 0, 0, 0),      mk_out(-32768, 0, 0, 0, 1)};
`else
    tab[3] = '{mk_in(32767, 0, 32767, 0, 16384, 0, 0, 0),        mk_out(-2, 0, 0, 0, 0)};
    tab[5] = '{mk_in(-32768, 0, -32768, 0, 16384, 0, 0, 0),      mk_out(0, 0, 0, 0, 0)};
`endif
    tab[4] = '{mk_in(32767, 0, 32767, 0, 16384, 0, 0, 1),        mk_out(32767, 0, 0, 0, 0)};
    tab[6] = '{mk_in(0, 0, 16384, 0, 0, -32768, 1, 0),           mk_out(0, 32767, 0, -32767, 0)};
    tab[7] = '{mk_in(0, 0, 1, 0, 8192, 0, 0, 0),                 mk_out(1, 0, -1, 0, 0)};
    tab[8] = '{mk_in(5, 5, -1, 0, 8192, 0, 0, 0),                mk_out(5, 5, 5, 5, 0)};
    tab[9] = '{mk_in(3, -3, 0, 0, 16384, 0, 0, 1),               mk_out(2, -1, 2, -1, 0)};
    z = mk_in(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    @(negedge clk); #1;
    chk_out("reset_outputs", get_out(), mk_out(0, 0, 0, 0, 0));
    chk_int("reset_out_valid", int'(out_valid), 0);
    chk_int("reset_in_ready", int'(in_ready), 1);
    @(negedge clk); rst = 1'b0; #1;
    chk_int("post_reset_in_ready", int'(in_ready), 1);

    // Directed table, back-to-back with fixed latency
    chk_lat = 1'b1;
    foreach (tab[i]) step(1'b1, tab[i].i, 1'b1, tab[i].o, f);
    drain();
    chk_lat = 1'b0;

    // Random stream with random bubbles and backpressure
    got = 0;
    for (int c = 0; c < 300 && got < 24; c++) begin
      v = rnd_in();
      step(1'($urandom_range(0, 3) != 0), v, 1'($urandom_range(0, 3) != 0), model(v), f);
      if (f) got++;
    end
    drain();

    // 5 beats, downstream stalls 4 cycles at the first output
    stalls = 0; hold_req = 4; got = 0;
    for (int c = 0; c < 100 && got < 5; c++) begin
      v = rnd_in();
      step(1'b1, v, 1'b1, model(v), f);
      if (f) got++;
    end
    drain();
    chk_int("bp_beats_accepted", got, 5);
    chk_int("bp_stall_cycles", stalls, 4);
    hold_req = 0;

    // Reset with beats in flight and the output stalled
    for (int k = 0; k < 3; k++) begin
      v = rnd_in();
      step(1'b1, v, 1'b1, model(v), f);
    end
    step(1'b0, z, 1'b0, mk_out(0, 0, 0, 0, 0), f);
    chk_int("pre_reset_out_valid", int'(out_valid), 1);
    #3 rst = 1'b1;
    #1;
    chk_int("midrst_out_valid", int'(out_valid), 0);
    chk_out("midrst_outputs", get_out(), mk_out(0, 0, 0, 0, 0));
    chk_int("midrst_in_ready", int'(in_ready), 1);
    sbq.delete();
    held = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b0; #1;
    chk_int("after_rst_in_ready", int'(in_ready), 1);
    for (int c = 0; c < 6; c++) step(1'b0, z, 1'b1, mk_out(0, 0, 0, 0, 0), f);
    chk_int("after_rst_out_valid", int'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
